// File: rtl/ahb3lite_burst_master_if.sv
// Bus bundle between the burst sequencer, its local requester and the AHB-Lite slave side.
// The master modport is the sequencer's view; slave is the requester/bus-model view.
interface ahb3lite_burst_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_burst;
  logic [2:0]        req_size;
  logic              req_write;
  logic [7:0]        req_len;
  logic              busy_req;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HBURST;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic              HREADY;
  logic              HRESP;

  logic              beat_done;
  logic [7:0]        beat_idx;
  logic              done;
  logic              err;

  modport master (
    input  req_valid, req_addr, req_burst, req_size, req_write, req_len, busy_req,
    input  HREADY, HRESP,
    output req_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE,
    output beat_done, beat_idx, done, err
  );

  modport slave (
    output req_valid, req_addr, req_burst, req_size, req_write, req_len, busy_req,
    output HREADY, HRESP,
    input  req_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE,
    input  beat_done, beat_idx, done, err
  );
endinterface

// File: rtl/ahb3lite_burst_master.sv
// AHB-Lite address-phase sequencer: takes one burst command at a time and drives
// HADDR/HTRANS/HBURST/HSIZE/HWRITE with BUSY insertion, wait states and ERROR abort.
//
// state  | meaning
// S_IDLE | ready for a command, bus idle
// S_ADDR | address phases outstanding (data phase of the previous beat may overlap)
// S_LAST | last address accepted, only the final data phase remains
// S_ERR  | second cycle of an ERROR response
module ahb3lite_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic HCLK,
  input  logic HRESET,
  ahb3lite_burst_master_if.master bus
);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_INCR   = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;
  state_t state, state_n;

  logic [ADDR_W-1:0] haddr, haddr_n;
  logic [ADDR_W-1:0] wrap_mask, wrap_mask_n;
  logic [1:0]        htrans, htrans_n;
  logic [2:0]        hburst, hburst_n;
  logic [2:0]        hsize, hsize_n;
  logic              hwrite, hwrite_n;
  logic [7:0]        rem, rem_n;
  logic [7:0]        cnt, cnt_n;
  logic [7:0]        beat_idx, beat_idx_n;
  logic              dp, dp_n;
  logic              beat_done, beat_done_n;
  logic              done, done_n;
  logic              err, err_n;
  logic              req_ready, req_ready_n;

  // command decode and legality
  logic [8:0]        req_beats;
  logic [4:0]        fix_beats;
  logic [12:0]       req_bytes;
  logic [ADDR_W-1:0] req_inc;
  logic              is_wrap, is_incr_fix, size_ok, align_ok, cross_1k, legal;

  always_comb begin
    fix_beats = 5'd1;
    case (bus.req_burst)
      3'b010, 3'b011: fix_beats = 5'd4;
      3'b100, 3'b101: fix_beats = 5'd8;
      3'b110, 3'b111: fix_beats = 5'd16;
      default:        fix_beats = 5'd1;
    endcase
    req_beats   = (bus.req_burst == BU_INCR) ? ({1'b0, bus.req_len} + 9'd1) : {4'd0, fix_beats};
    req_bytes   = 13'(fix_beats) << bus.req_size;
    req_inc     = ADDR_W'(1) << bus.req_size;
    is_wrap     = (bus.req_burst == 3'b010) || (bus.req_burst == 3'b100) || (bus.req_burst == 3'b110);
    is_incr_fix = (bus.req_burst == 3'b011) || (bus.req_burst == 3'b101) || (bus.req_burst == 3'b111);
    size_ok     = ({29'd0, bus.req_size} <= 32'(MAX_SIZE));
    align_ok    = ((bus.req_addr & (req_inc - ADDR_W'(1))) == '0);
    cross_1k    = is_incr_fix && (({3'b000, bus.req_addr[9:0]} + req_bytes) > 13'd1024);
    legal       = size_ok && align_ok && !cross_1k;
  end

  // next beat address; non-wrapping bursts keep an all-ones mask so this reduces to addr+inc
  logic [ADDR_W-1:0] addr_step, addr_nxt;
  logic [1:0]        nxt_trans;

  always_comb begin
    addr_step = haddr + (ADDR_W'(1) << hsize);
    addr_nxt  = (haddr & ~wrap_mask) | (addr_step & wrap_mask);
    nxt_trans = ((hburst == BU_INCR) && (addr_nxt[9:0] == 10'd0)) ? TR_NONSEQ : TR_SEQ;
  end

  always_comb begin
    state_n     = state;
    haddr_n     = haddr;
    wrap_mask_n = wrap_mask;
    htrans_n    = htrans;
    hburst_n    = hburst;
    hsize_n     = hsize;
    hwrite_n    = hwrite;
    rem_n       = rem;
    cnt_n       = cnt;
    beat_idx_n  = beat_idx;
    dp_n        = dp;
    beat_done_n = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.req_valid && req_ready) begin
          if (legal) begin
            haddr_n     = bus.req_addr;
            htrans_n    = TR_NONSEQ;
            hburst_n    = bus.req_burst;
            hsize_n     = bus.req_size;
            hwrite_n    = bus.req_write;
            wrap_mask_n = is_wrap ? ADDR_W'(req_bytes - 13'd1) : '1;
            rem_n       = 8'(req_beats - 9'd1);
            cnt_n       = 8'd0;
            dp_n        = 1'b0;
            state_n     = S_ADDR;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (dp && bus.HRESP) begin
          htrans_n = TR_IDLE;
          if (!bus.HREADY) begin
            state_n = S_ERR;
          end else begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            dp_n    = 1'b0;
            state_n = S_IDLE;
          end
        end else if (bus.HREADY) begin
          if (dp) begin
            beat_done_n = 1'b1;
            beat_idx_n  = cnt;
            cnt_n       = cnt + 8'd1;
          end
          if (htrans == TR_BUSY) begin
            // BUSY has no data phase; HADDR already holds the pending beat
            dp_n = 1'b0;
            if (!bus.busy_req) begin
              htrans_n = TR_SEQ;
              rem_n    = rem - 8'd1;
            end
          end else begin
            dp_n = 1'b1;
            if (rem == 8'd0) begin
              htrans_n = TR_IDLE;
              state_n  = S_LAST;
            end else begin
              haddr_n = addr_nxt;
              if (bus.busy_req && (nxt_trans == TR_SEQ)) begin
                htrans_n = TR_BUSY;
              end else begin
                htrans_n = nxt_trans;
                rem_n    = rem - 8'd1;
              end
            end
          end
        end
      end

      S_LAST: begin
        if (bus.HRESP) begin
          if (!bus.HREADY) begin
            state_n = S_ERR;
          end else begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            dp_n    = 1'b0;
            state_n = S_IDLE;
          end
        end else if (bus.HREADY) begin
          beat_done_n = 1'b1;
          beat_idx_n  = cnt;
          cnt_n       = cnt + 8'd1;
          done_n      = 1'b1;
          dp_n        = 1'b0;
          state_n     = S_IDLE;
        end
      end

      S_ERR: begin
        if (bus.HREADY) begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          dp_n    = 1'b0;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase

    req_ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      haddr     <= '0;
      wrap_mask <= '1;
      htrans    <= TR_IDLE;
      hburst    <= 3'b000;
      hsize     <= 3'b000;
      hwrite    <= 1'b0;
      rem       <= 8'd0;
      cnt       <= 8'd0;
      beat_idx  <= 8'd0;
      dp        <= 1'b0;
      beat_done <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_n;
      haddr     <= haddr_n;
      wrap_mask <= wrap_mask_n;
      htrans    <= htrans_n;
      hburst    <= hburst_n;
      hsize     <= hsize_n;
      hwrite    <= hwrite_n;
      rem       <= rem_n;
      cnt       <= cnt_n;
      beat_idx  <= beat_idx_n;
      dp        <= dp_n;
      beat_done <= beat_done_n;
      done      <= done_n;
      err       <= err_n;
      req_ready <= req_ready_n;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.HADDR     = haddr;
  assign bus.HTRANS    = htrans;
  assign bus.HBURST    = hburst;
  assign bus.HSIZE     = hsize;
  assign bus.HWRITE    = hwrite;
  assign bus.beat_done = beat_done;
  assign bus.beat_idx  = beat_idx;
  assign bus.done      = done;
  assign bus.err       = err;
endmodule

// File: tb/tb_ahb3lite_burst_master.sv
// Directed bench for ahb3lite_burst_master: a table of zero-wait commands with hand-computed
// address/HTRANS sequences, plus cycle scripts for stalls, BUSY, ERROR abort and async reset.
module tb_ahb3lite_burst_master;
  logic clk;
  logic rst;

  ahb3lite_burst_master_if #(.ADDR_W(32)) bus ();

  ahb3lite_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]       addr;
    logic [2:0]        burst;
    logic [2:0]        size;
    logic              write;
    logic [7:0]        len;
    int                n;      // 0 means the command must be rejected
    logic [15:0][31:0] ea;
    logic [15:0][1:0]  et;
  } vec_t;

  typedef struct {
    logic        hr, rs, bz;
    logic        ct;
    logic [31:0] ea;
    logic [1:0]  et;
    logic        bd;
    logic [7:0]  bi;
    logic        dn, er;
  } row_t;

  vec_t vec[12];
  row_t sq[16];
  int   nsq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic row_t R(input logic hr, rs, bz, ct, input logic [31:0] ea,
                             input logic [1:0] et, input logic bd, input logic [7:0] bi,
                             input logic dn, er);
    row_t r;
    r.hr = hr; r.rs = rs; r.bz = bz; r.ct = ct; r.ea = ea; r.et = et;
    r.bd = bd; r.bi = bi; r.dn = dn; r.er = er;
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " HADDR"},     bus.HADDR, 32'h0);
    chk({tag, " HTRANS"},    32'(bus.HTRANS), 32'h0);
    chk({tag, " HBURST"},    32'(bus.HBURST), 32'h0);
    chk({tag, " HSIZE"},     32'(bus.HSIZE), 32'h0);
    chk({tag, " HWRITE"},    32'(bus.HWRITE), 32'h0);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'h1);
    chk({tag, " beat_done"}, 32'(bus.beat_done), 32'h0);
    chk({tag, " beat_idx"},  32'(bus.beat_idx), 32'h0);
    chk({tag, " done"},      32'(bus.done), 32'h0);
    chk({tag, " err"},       32'(bus.err), 32'h0);
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic [2:0] bu, input logic [2:0] sz,
                           input logic wr, input logic [7:0] ln);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_burst = bu;
    bus.req_size  = sz;
    bus.req_write = wr;
    bus.req_len   = ln;
  endtask

  task automatic run_vec(input int k);
    vec_t t;
    int   last;
    bit   bd;
    t = vec[k];
    last = (t.n == 0) ? 2 : t.n + 2;
    @(negedge clk);
    chk($sformatf("v%0d ready_before", k), 32'(bus.req_ready), 32'h1);
    drive_cmd(t.addr, t.burst, t.size, t.write, t.len);
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.busy_req = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (t.n == 0) begin
        chk($sformatf("v%0d c%0d rej_err", k, c), 32'(bus.err), (c == 1) ? 32'h1 : 32'h0);
        chk($sformatf("v%0d c%0d rej_htrans", k, c), 32'(bus.HTRANS), 32'(I));
        chk($sformatf("v%0d c%0d rej_done", k, c), 32'(bus.done), 32'h0);
        chk($sformatf("v%0d c%0d rej_ready", k, c), 32'(bus.req_ready), 32'h1);
      end else begin
        if (c <= t.n) begin
          chk($sformatf("v%0d c%0d HADDR", k, c), bus.HADDR, t.ea[c-1]);
          chk($sformatf("v%0d c%0d HTRANS", k, c), 32'(bus.HTRANS), 32'(t.et[c-1]));
          chk($sformatf("v%0d c%0d HBURST", k, c), 32'(bus.HBURST), 32'(t.burst));
        end else begin
          chk($sformatf("v%0d c%0d HTRANS_idle", k, c), 32'(bus.HTRANS), 32'(I));
        end
        if (c == 1) begin
          chk($sformatf("v%0d HSIZE", k), 32'(bus.HSIZE), 32'(t.size));
          chk($sformatf("v%0d HWRITE", k), 32'(bus.HWRITE), 32'(t.write));
        end
        bd = (c >= 3);
        chk($sformatf("v%0d c%0d beat_done", k, c), 32'(bus.beat_done), 32'(bd));
        if (bd) chk($sformatf("v%0d c%0d beat_idx", k, c), 32'(bus.beat_idx), 32'(c - 3));
        chk($sformatf("v%0d c%0d done", k, c), 32'(bus.done), (c == last) ? 32'h1 : 32'h0);
        chk($sformatf("v%0d c%0d err", k, c), 32'(bus.err), 32'h0);
        chk($sformatf("v%0d c%0d req_ready", k, c), 32'(bus.req_ready), (c == last) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic run_seq(input string tag, input logic [31:0] a, input logic [2:0] bu,
                         input logic [2:0] sz, input logic wr);
    @(negedge clk);
    drive_cmd(a, bu, sz, wr, 8'd0);
    bus.HREADY = sq[0].hr; bus.HRESP = sq[0].rs; bus.busy_req = sq[0].bz;
    for (int c = 1; c < nsq; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.HREADY = sq[c].hr; bus.HRESP = sq[c].rs; bus.busy_req = sq[c].bz;
      if (sq[c].ct) chk($sformatf("%s c%0d HADDR", tag, c), bus.HADDR, sq[c].ea);
      chk($sformatf("%s c%0d HTRANS", tag, c), 32'(bus.HTRANS), 32'(sq[c].et));
      chk($sformatf("%s c%0d beat_done", tag, c), 32'(bus.beat_done), 32'(sq[c].bd));
      if (sq[c].bd) chk($sformatf("%s c%0d beat_idx", tag, c), 32'(bus.beat_idx), 32'(sq[c].bi));
      chk($sformatf("%s c%0d done", tag, c), 32'(bus.done), 32'(sq[c].dn));
      chk($sformatf("%s c%0d err", tag, c), 32'(bus.err), 32'(sq[c].er));
    end
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.busy_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (vec[k]) begin
      vec[k].addr = '0; vec[k].burst = '0; vec[k].size = '0; vec[k].write = 1'b0;
      vec[k].len = '0; vec[k].n = 0; vec[k].ea = '0; vec[k].et = '0;
    end
    // INCR4 WORD 0x100
    vec[0].addr = 32'h100; vec[0].burst = 3'b011; vec[0].size = 3'b010; vec[0].write = 1'b1; vec[0].n = 4;
    vec[0].ea[0] = 32'h100; vec[0].ea[1] = 32'h104; vec[0].ea[2] = 32'h108; vec[0].ea[3] = 32'h10C;
    vec[0].et[0] = N; vec[0].et[1] = S; vec[0].et[2] = S; vec[0].et[3] = S;
    // WRAP8 HALF 0x3C
    vec[1].addr = 32'h3C; vec[1].burst = 3'b100; vec[1].size = 3'b001; vec[1].n = 8;
    vec[1].ea[0] = 32'h3C; vec[1].ea[1] = 32'h3E; vec[1].ea[2] = 32'h30; vec[1].ea[3] = 32'h32;
    vec[1].ea[4] = 32'h34; vec[1].ea[5] = 32'h36; vec[1].ea[6] = 32'h38; vec[1].ea[7] = 32'h3A;
    vec[1].et[0] = N; for (int i = 1; i < 8; i++) vec[1].et[i] = S;
    // WRAP4 WORD 0x38
    vec[2].addr = 32'h38; vec[2].burst = 3'b010; vec[2].size = 3'b010; vec[2].write = 1'b1; vec[2].n = 4;
    vec[2].ea[0] = 32'h38; vec[2].ea[1] = 32'h3C; vec[2].ea[2] = 32'h30; vec[2].ea[3] = 32'h34;
    vec[2].et[0] = N; vec[2].et[1] = S; vec[2].et[2] = S; vec[2].et[3] = S;
    // INCR len=3 WORD 0x3F8 crossing 1 KB: re-issued NONSEQ at 0x400
    vec[3].addr = 32'h3F8; vec[3].burst = 3'b001; vec[3].size = 3'b010; vec[3].len = 8'd3; vec[3].n = 4;
    vec[3].ea[0] = 32'h3F8; vec[3].ea[1] = 32'h3FC; vec[3].ea[2] = 32'h400; vec[3].ea[3] = 32'h404;
    vec[3].et[0] = N; vec[3].et[1] = S; vec[3].et[2] = N; vec[3].et[3] = S;
    // SINGLE BYTE at odd address
    vec[4].addr = 32'h123; vec[4].burst = 3'b000; vec[4].size = 3'b000; vec[4].n = 1;
    vec[4].ea[0] = 32'h123; vec[4].et[0] = N;
    // INCR16 WORD 0x3C0 ends exactly at 0x3FF: legal
    vec[5].addr = 32'h3C0; vec[5].burst = 3'b111; vec[5].size = 3'b010; vec[5].write = 1'b1; vec[5].n = 16;
    for (int i = 0; i < 16; i++) begin
      vec[5].ea[i] = 32'h3C0 + 32'(4 * i);
      vec[5].et[i] = (i == 0) ? N : S;
    end
    // WRAP16 BYTE 0x7: 0x7..0xF then 0x0..0x6
    vec[6].addr = 32'h7; vec[6].burst = 3'b110; vec[6].size = 3'b000; vec[6].n = 16;
    for (int i = 0; i < 16; i++) begin
      vec[6].ea[i] = 32'((7 + i) % 16);
      vec[6].et[i] = (i == 0) ? N : S;
    end
    // rejects: oversize, misaligned, INCR4 crossing 1 KB
    vec[7].addr = 32'h100; vec[7].burst = 3'b000; vec[7].size = 3'b011; vec[7].n = 0;
    vec[8].addr = 32'h102; vec[8].burst = 3'b011; vec[8].size = 3'b010; vec[8].n = 0;
    vec[9].addr = 32'h3FC; vec[9].burst = 3'b011; vec[9].size = 3'b010; vec[9].n = 0;
    // INCR len=0 HALF: one beat
    vec[10].addr = 32'h400; vec[10].burst = 3'b001; vec[10].size = 3'b001; vec[10].n = 1;
    vec[10].ea[0] = 32'h400; vec[10].et[0] = N;
    // INCR8 HALF 0x3F4 ends at 0x403: rejected
    vec[11].addr = 32'h3F4; vec[11].burst = 3'b101; vec[11].size = 3'b001; vec[11].n = 0;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_burst = '0; bus.req_size = '0;
    bus.req_write = 1'b0; bus.req_len = '0; bus.busy_req = 1'b0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset_in");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset_out");

    for (int k = 0; k < 12; k++) run_vec(k);

    // INCR8 WORD 0x200: 2-cycle stall on beat 2, one BUSY before beat 5, busy ignored at start/end
    nsq = 15;
    sq[0]  = R(1, 0, 1, 0, 32'h0,   I, 0, 0, 0, 0);
    sq[1]  = R(1, 0, 0, 1, 32'h200, N, 0, 0, 0, 0);
    sq[2]  = R(1, 0, 0, 1, 32'h204, S, 0, 0, 0, 0);
    sq[3]  = R(0, 0, 0, 1, 32'h208, S, 1, 0, 0, 0);
    sq[4]  = R(0, 0, 0, 1, 32'h208, S, 0, 0, 0, 0);
    sq[5]  = R(1, 0, 0, 1, 32'h208, S, 0, 0, 0, 0);
    sq[6]  = R(1, 0, 0, 1, 32'h20C, S, 1, 1, 0, 0);
    sq[7]  = R(1, 0, 1, 1, 32'h210, S, 1, 2, 0, 0);
    sq[8]  = R(1, 0, 0, 1, 32'h214, B, 1, 3, 0, 0);
    sq[9]  = R(1, 0, 0, 1, 32'h214, S, 1, 4, 0, 0);
    sq[10] = R(1, 0, 0, 1, 32'h218, S, 0, 0, 0, 0);
    sq[11] = R(1, 0, 1, 1, 32'h21C, S, 1, 5, 0, 0);
    sq[12] = R(1, 0, 1, 0, 32'h0,   I, 1, 6, 0, 0);
    sq[13] = R(1, 0, 0, 0, 32'h0,   I, 1, 7, 1, 0);
    sq[14] = R(1, 0, 0, 0, 32'h0,   I, 0, 0, 0, 0);
    run_seq("stall_busy", 32'h200, 3'b101, 3'b010, 1'b1);

    // INCR8 WORD 0x300: two-cycle ERROR on the data phase of beat 2
    nsq = 9;
    sq[0] = R(1, 0, 0, 0, 32'h0,   I, 0, 0, 0, 0);
    sq[1] = R(1, 0, 0, 1, 32'h300, N, 0, 0, 0, 0);
    sq[2] = R(1, 0, 0, 1, 32'h304, S, 0, 0, 0, 0);
    sq[3] = R(1, 0, 0, 1, 32'h308, S, 1, 0, 0, 0);
    sq[4] = R(0, 1, 0, 1, 32'h30C, S, 1, 1, 0, 0);
    sq[5] = R(1, 1, 0, 0, 32'h0,   I, 0, 0, 0, 0);
    sq[6] = R(1, 0, 0, 0, 32'h0,   I, 0, 0, 1, 1);
    sq[7] = R(1, 0, 0, 0, 32'h0,   I, 0, 0, 0, 0);
    sq[8] = R(1, 0, 0, 0, 32'h0,   I, 0, 0, 0, 0);
    run_seq("error", 32'h300, 3'b101, 3'b010, 1'b0);

    // async reset during beat 3 of INCR8 WORD 0x400
    @(negedge clk);
    drive_cmd(32'h400, 3'b101, 3'b010, 1'b1, 8'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk($sformatf("rst_burst c%0d HADDR", c), bus.HADDR, 32'h400 + 32'(4 * (c - 1)));
    end
    #2 rst = 1'b1;
    #1 chk_reset("rst_async");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_after c%0d done", c), 32'(bus.done), 32'h0);
      chk($sformatf("rst_after c%0d HTRANS", c), 32'(bus.HTRANS), 32'(I));
      chk($sformatf("rst_after c%0d req_ready", c), 32'(bus.req_ready), 32'h1);
    end

    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb3lite_burst_master.md
# ahb3lite_burst_master

Parametrised AHB-Lite master address-phase sequencer. It accepts one burst command at a time from a local requester over a valid/ready handshake. It drives HADDR/HTRANS/HBURST/HSIZE/HWRITE for every HBURST type (SINGLE, INCR, WRAP4/8/16, INCR4/8/16), with optional BUSY insertion, wait-state stalling and two-cycle ERROR abort. It sits between the test/traffic generator and the AHB-Lite bus and generalises the fixed-WORD, single/burst-check behaviour of the existing AHB-Lite types to any data width and transfer size.

## Interface
- ADDR_W, 32, address width (≥ 11)
- DATA_W, 32, bus data width in bits (8..1024, power of 2); MAX_SIZE = log2(DATA_W/8)
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready at HCLK edge
- req_addr  in  ADDR_W  start address
- req_burst  in  3  HBURST encoding (SINGLE=000 … INCR16=111)
- req_size  in  3  HSIZE encoding (BYTE=000, HALF=001, WORD=010 …)
- req_write  in  1  direction
- req_len  in  8  beats−1, used only for INCR (1..256 beats)
- busy_req  in  1  insert BUSY instead of next SEQ while high
- HADDR  out  ADDR_W;  HTRANS  out  2;  HBURST  out  3;  HSIZE  out  3;  HWRITE  out  1
- HREADY  in  1;  HRESP  in  1 (OKAY=0, ERROR=1)
- beat_done  out  1  one-cycle pulse per data phase completed OKAY
- beat_idx  out  8  index of beat reported by beat_done
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse with done on ERROR abort, or alone on rejected command

## Operation
- FSM states: IDLE, ADDR (address phases outstanding), LAST (final data phase only), ERR (second error cycle).
- IDLE: req_ready=1, HTRANS=IDLE. On accept:
  - Legality check: req_size ≤ MAX_SIZE; req_addr aligned to 1<<req_size; INCR4/8/16 must not cross a 1 KB boundary.
  - Illegal: no bus transfer; err pulses next cycle; stay IDLE.
  - Legal: latch command and go to ADDR.
- Beats: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=req_len+1.
- Increment inc = 1<<size.
  - INCR*: next = addr+inc.
  - WRAPn: boundary B = beats·inc; next = (addr & ~(B−1)) | ((addr+inc) & (B−1)).
- HTRANS: first beat NONSEQ, later beats SEQ.
  - INCR (undefined length) only: a beat whose address is on a 1 KB boundary is issued NONSEQ. HBURST stays INCR.
- BUSY: if busy_req=1 when the next issued beat would be SEQ, drive HTRANS=BUSY with HADDR = pending next address; beat count does not advance. BUSY is never issued before the first beat or after the last.
- After the last address phase is accepted (HREADY=1), HTRANS=IDLE and the FSM enters LAST. When the last data phase completes OKAY, done pulses and the FSM returns to IDLE.
- ERROR: HRESP=1 & HREADY=0 in any data phase:
  - Next cycle: HTRANS=IDLE and the FSM enters ERR, regardless of remaining beats. The pending address is never sampled because HREADY=0.
  - Second error cycle (HRESP=1 & HREADY=1): done and err pulse; return to IDLE; no beat_done for the errored beat.
- beat_idx counts completed data phases 0..beats−1. BUSY cycles never produce beat_done.

## Timing
- All outputs registered.
- Reset values: HADDR=0, HTRANS=IDLE(00), HBURST=SINGLE, HSIZE=000, HWRITE=0, req_ready=1, beat_done=0, beat_idx=0, done=0, err=0, FSM=IDLE.
- Reset asserted mid-burst forces the reset values asynchronously. The burst is dropped and no done is issued.
- First NONSEQ appears in the cycle after the accept edge.
- Address/control outputs advance only on edges where HREADY=1. The ERROR cancel to IDLE is the only change allowed with HREADY=0.
- beat_done/beat_idx and done/err assert in the cycle after the completing HREADY=1 edge.
- Zero wait states: an N-beat burst accepted at edge 0 drives beats in cycles 1..N and asserts done in cycle N+2.
- req_ready=1 only in IDLE. The next command is accepted at the earliest on the edge at which done is high, so back-to-back bursts have a one-cycle HTRANS=IDLE gap.
- busy_req is sampled on the edge that would issue the next beat.

## Test plan
- INCR4 WORD at 0x100, HREADY=1 → HADDR 0x100/104/108/10C with NONSEQ,SEQ,SEQ,SEQ in cycles 1–4; beat_idx 0..3; done in cycle 6, err=0.
- WRAP8 HALF at 0x3C → HADDR 0x3C,3E,30,32,34,36,38,3A; HBURST=100; WRAP4 WORD at 0x38 → 0x38,3C,30,34.
- INCR, req_len=3, WORD at 0x3F8 → 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- INCR8 WORD with HREADY low for 2 cycles on beat 2 and busy_req high for 1 cycle before beat 5 → HADDR/HTRANS held during stall; one BUSY cycle carrying beat-5 address; 8 beat_done.
- INCR8 with two-cycle ERROR on beat 2 data phase → HTRANS=IDLE in second error cycle; done+err pulse; only 2 beat_done; no further NONSEQ/SEQ.
- Rejects: req_size=011 with DATA_W=32, or WORD at 0x102 → err pulse, HTRANS stays IDLE. HRESET during beat 3 → outputs at reset values immediately, no done.
